rom2ram_loader_multi: RTL and testbench

Parametrised, restartable ROM-to-RAM bulk loader for the line/triangle pipeline. It copies a programmable run of words (base addresses and count set per transfer) from an external ROM with configurable read latency into an internal multi-read-port RAM. Once the load completes, that RAM serves NUM_RD consecutive words per read address to the rasteriser. It supports reload, abort and empty transfers, and it never locks up after the first load.

---
 rtl/rom2ram_loader_multi_pkg.sv | 26 ++
 rtl/rom2ram_loader_multi_multiread_ram.sv | 49 ++++
 rtl/rom2ram_loader_multi.sv | 188 ++++++++++++++++++
 tb/tb_rom2ram_loader_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom2ram_loader_multi_pkg.sv
// rom2ram_loader_multi_pkg
//   Shared definitions for the ROM-to-RAM bulk loader:
//     - state_e          : loader FSM encoding (IDLE=0, FILL=1, DRAIN=2, LOADED=3)
//     - MAX_ROM_LATENCY  : largest supported ROM read latency
//     - clamp_count()    : limits a requested word count to the RAM depth
package rom2ram_loader_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_LOADED = 2'd3
    } state_e;

    localparam int MAX_ROM_LATENCY = 4;

    // Requests larger than the RAM depth would rewrite locations; cap them so
    // a maximal copy touches every location exactly once.
    function automatic logic [31:0] clamp_count(input logic [31:0] wc,
                                                input int unsigned aw);
        logic [31:0] depth;
        depth = 32'd1 << aw;
        return (wc > depth) ? depth : wc;
    endfunction

endpackage

// File: rtl/rom2ram_loader_multi_multiread_ram.sv
// multiread_ram
//   Single-write, multi-word-read RAM. Each read address returns NUM_RD
//   consecutive words (wrapping modulo depth), registered on the clock edge.
//   The array is not reset; contents persist until overwritten.
//
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read base address
//   rdata_o  out  NUM_RD words, slice i = mem[(raddr_i + i) mod depth]
module multiread_ram
    import rom2ram_loader_multi_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 4
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [ADDR_WIDTH-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [ADDR_WIDTH-1:0]        raddr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0]        mem_q [2**ADDR_WIDTH];
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0]        ra [NUM_RD];

    // Per-port addresses are truncated to ADDR_WIDTH, giving the modulo wrap.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            ra[i] = raddr_i + ADDR_WIDTH'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        for (int i = 0; i < NUM_RD; i++) begin
            rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem_q[ra[i]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rom2ram_loader_multi.sv
// rom2ram_loader_multi
//   Restartable ROM-to-RAM bulk loader. On start it copies word_count words
//   (clamped to the RAM depth) from ROM[src_base..] to RAM[dst_base..], both
//   wrapping modulo depth, tracking the ROM read latency with a valid/index
//   shift pipeline. Once LOADED, the RAM serves NUM_RD consecutive words per
//   read address. abort returns to IDLE from any state and flushes pending
//   writes.
//
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset (control state only)
//   start       in   begin a transfer; honoured in IDLE or LOADED
//   abort       in   return to IDLE; wins over start
//   src_base    in   first ROM address, sampled with start
//   dst_base    in   first RAM address, sampled with start
//   word_count  in   words to copy, sampled with start
//   rom_addr    out  ROM read address (0 outside FILL)
//   rom_data    in   ROM data, ROM_LATENCY cycles after rom_addr
//   busy        out  high in FILL and DRAIN
//   ready       out  high in LOADED
//   done        out  one-cycle pulse on entry to LOADED
//   rd_addr     in   RAM read base address
//   rd_data     out  NUM_RD registered words, 0 unless LOADED
module rom2ram_loader_multi
    import rom2ram_loader_multi_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_RD      = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_WIDTH-1:0]        src_base,
    input  logic [ADDR_WIDTH-1:0]        dst_base,
    input  logic [ADDR_WIDTH:0]          word_count,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic [DATA_WIDTH-1:0]        rom_data,
    output logic                         busy,
    output logic                         ready,
    output logic                         done,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data
);

    localparam int CW     = ADDR_WIDTH + 1;
    // Keep at least one stage so the vectors stay legal when ROM_LATENCY=0.
    localparam int PIPE_D = (ROM_LATENCY > 0) ? ROM_LATENCY : 1;

    state_e                state_q;
    logic [CW-1:0]         k_q;
    logic [CW-1:0]         n_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic                  done_q;
    logic [PIPE_D-1:0]     vld_q;
    logic [ADDR_WIDTH-1:0] idx_q [PIPE_D];

    logic [CW-1:0]         n_d;
    logic                  issue;
    logic                  last_issue;
    logic                  pipe_upper_busy;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [NUM_RD*DATA_WIDTH-1:0] ram_rdata;

    assign n_d        = CW'(clamp_count(32'(word_count), ADDR_WIDTH));
    assign issue      = (state_q == ST_FILL);
    assign last_issue = issue && (k_q == n_q - CW'(1));

    // Words still short of the last stage keep DRAIN waiting; the word in the
    // last stage is written this cycle, so LOADED can follow directly.
    always_comb begin
        pipe_upper_busy = 1'b0;
        for (int i = 0; i < PIPE_D - 1; i++) begin
            pipe_upper_busy = pipe_upper_busy | vld_q[i];
        end
    end

    always_comb begin
        if (ROM_LATENCY == 0) begin
            ram_we = issue;
            wr_idx = k_q[ADDR_WIDTH-1:0];
        end else begin
            ram_we = vld_q[PIPE_D-1];
            wr_idx = idx_q[PIPE_D-1];
        end
    end

    assign ram_waddr = dst_q + wr_idx;

    // FSM, transfer parameters and issue counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                k_q     <= '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_LOADED: begin
                        if (start) begin
                            src_q <= src_base;
                            dst_q <= dst_base;
                            n_q   <= n_d;
                            k_q   <= '0;
                            if (n_d == '0) begin
                                state_q <= ST_LOADED;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_FILL;
                            end
                        end
                    end
                    ST_FILL: begin
                        k_q <= k_q + CW'(1);
                        if (last_issue) begin
                            if (ROM_LATENCY == 0) begin
                                state_q <= ST_LOADED;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!pipe_upper_busy) begin
                            state_q <= ST_LOADED;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Latency pipeline: valid bits (control, reset and flushed on abort)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else if (abort) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue && (ROM_LATENCY != 0);
            for (int i = 1; i < PIPE_D; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Latency pipeline: word indices travelling alongside the valid bits
    always_ff @(posedge clk) begin
        idx_q[0] <= k_q[ADDR_WIDTH-1:0];
        for (int i = 1; i < PIPE_D; i++) begin
            idx_q[i] <= idx_q[i-1];
        end
    end

    multiread_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_RD     (NUM_RD)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (rom_data),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    assign rom_addr = issue ? (src_q + k_q[ADDR_WIDTH-1:0]) : '0;
    assign busy     = (state_q == ST_FILL) || (state_q == ST_DRAIN);
    assign ready    = (state_q == ST_LOADED);
    assign done     = done_q;
    assign rd_data  = (state_q == ST_LOADED) ? ram_rdata : '0;

endmodule

// File: tb/tb_rom2ram_loader_multi.sv
// tb_rom2ram_loader_multi
//   Drives two loaders (ROM latency 1 and 3) with the same transfer requests.
//   Each has its own latency-accurate ROM model returning rom_ofs + address.
module tb_rom2ram_loader_multi;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 4;

    typedef struct {
        int           id;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   wc;
        int           n;       // hand-clamped word count
        int           glitch;  // cycle of an extra start pulse while busy, -1 none
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [AW:0]   word_count;
    logic [AW-1:0] rd_addr;

    logic [AW-1:0]    rom_addr1, rom_addr3;
    logic [DW-1:0]    rom_data1, rom_data3;
    logic             busy1, busy3, ready1, ready3, done1, done3;
    logic [NR*DW-1:0] rd_data1, rd_data3;

    logic [DW-1:0] rom_ofs = 32'h100;
    logic [DW-1:0] r3a, r3b;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return rom_ofs + DW'(a);
    endfunction

    always @(posedge clk) rom_data1 <= rom_fn(rom_addr1);
    always @(posedge clk) begin
        r3a       <= rom_fn(rom_addr3);
        r3b       <= r3a;
        rom_data3 <= r3b;
    end

    rom2ram_loader_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .ROM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .word_count(word_count),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .busy(busy1), .ready(ready1), .done(done1),
        .rd_addr(rd_addr), .rd_data(rd_data1)
    );

    rom2ram_loader_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .ROM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .word_count(word_count),
        .rom_addr(rom_addr3), .rom_data(rom_data3),
        .busy(busy3), .ready(ready3), .done(done3),
        .rd_addr(rd_addr), .rd_data(rd_data3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            0:       return "done";
            1:       return "busy";
            2:       return "ready";
            3:       return "ram_we";
            default: return "rom_addr";
        endcase
    endfunction

    // Reads one base address and checks every slice that the last transfer wrote.
    task automatic read_words(input string tag, input logic [AW-1:0] src,
                              input logic [AW-1:0] dst, input logic [AW-1:0] addr,
                              input int n);
        logic [AW-1:0] o8;
        @(negedge clk);
        rd_addr = addr;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            o8 = addr - dst + AW'(i);
            if (int'(o8) < n) begin
                chk($sformatf("%s rd@%0h slice%0d L1", tag, addr, i),
                    64'(rd_data1[i*DW +: DW]), 64'(rom_fn(src + o8)));
                chk($sformatf("%s rd@%0h slice%0d L3", tag, addr, i),
                    64'(rd_data3[i*DW +: DW]), 64'(rom_fn(src + o8)));
            end
        end
    endtask

    // Runs one transfer and compares done/busy/ready/ram_we/rom_addr every cycle.
    task automatic run_xfer(input vec_t v);
        int bad [2][5];
        int first [2][5];
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 5; s++) begin
                bad[d][s]   = 0;
                first[d][s] = -1;
            end
        rom_ofs = 32'h100 + 32'(v.id) * 32'h10000;
        @(negedge clk);
        src_base   = v.src;
        dst_base   = v.dst;
        word_count = v.wc;
        start      = 1'b1;
        for (int c = 0; c <= v.n + 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int            lat;
                int            t_done;
                logic [3:0]    f_exp;
                logic [3:0]    f_act;
                logic [AW-1:0] a_exp;
                logic [AW-1:0] a_act;
                lat      = (d == 0) ? 1 : 3;
                t_done   = (v.n == 0) ? 0 : v.n + lat;
                f_exp[0] = (c == t_done);
                f_exp[1] = (c < t_done);
                f_exp[2] = (c >= t_done);
                f_exp[3] = (v.n > 0) && (c >= lat) && (c < v.n + lat);
                f_act    = (d == 0) ? {u_dut1.ram_we, ready1, busy1, done1}
                                    : {u_dut3.ram_we, ready3, busy3, done3};
                a_exp    = (c < v.n) ? v.src + AW'(c) : '0;
                a_act    = (d == 0) ? rom_addr1 : rom_addr3;
                for (int s = 0; s < 4; s++) begin
                    if (f_act[s] !== f_exp[s]) begin
                        if (bad[d][s] == 0) first[d][s] = c;
                        bad[d][s]++;
                    end
                end
                if (a_act !== a_exp) begin
                    if (bad[d][4] == 0) first[d][4] = c;
                    bad[d][4]++;
                end
            end
            start = (c == v.glitch);
            if (c == v.glitch) begin
                src_base   = ~v.src;
                dst_base   = ~v.dst;
                word_count = 9'd1;
            end
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 5; s++)
                chk($sformatf("v%0d L%0d %s bad_cycles (first at cycle %0d)",
                              v.id, (d == 0) ? 1 : 3, sig_name(s), first[d][s]),
                    64'(bad[d][s]), 64'd0);
        if (v.n > 0) read_words($sformatf("v%0d", v.id), v.src, v.dst, v.dst, v.n);
        if (v.n >= 2) read_words($sformatf("v%0d", v.id), v.src, v.dst, v.dst + AW'(v.n - 2), v.n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          vecs [7];
        logic [DW-1:0] hand [NR];
        int            bad1, bad3, pre1, pre3;

        vecs[0] = '{0, 8'h00, 8'h00, 9'd7,   7,   -1};
        vecs[1] = '{1, 8'hFE, 8'hFD, 9'd4,   4,   -1};
        vecs[2] = '{2, 8'h10, 8'h40, 9'd5,   5,   -1};
        vecs[3] = '{3, 8'h33, 8'h44, 9'd0,   0,   -1};
        vecs[4] = '{4, 8'h03, 8'h80, 9'd300, 256, -1};
        vecs[5] = '{5, 8'h20, 8'h90, 9'd10,  10,  2};
        vecs[6] = '{6, 8'h00, 8'h00, 9'd256, 256, -1};
        hand    = '{32'h102, 32'h103, 32'h104, 32'h105};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_base = '0; dst_base = '0; word_count = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset flags L1", 64'({busy1, ready1, done1}), 64'd0);
        chk("reset flags L3", 64'({busy3, ready3, done3}), 64'd0);
        chk("reset rom_addr L1", 64'(rom_addr1), 64'd0);
        chk("reset rd_data L1", 64'(rd_data1[63:0]), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle after reset L1", 64'({busy1, ready1, done1}), 64'd0);
        chk("idle after reset L3", 64'({busy3, ready3, done3}), 64'd0);

        for (int v = 0; v < 7; v++) begin
            run_xfer(vecs[v]);
            if (v == 0) begin
                @(negedge clk);
                rd_addr = 8'h02;
                @(negedge clk);
                for (int i = 0; i < NR; i++) begin
                    chk($sformatf("hand rd@2 slice%0d L1", i), 64'(rd_data1[i*DW +: DW]), 64'(hand[i]));
                    chk($sformatf("hand rd@2 slice%0d L3", i), 64'(rd_data3[i*DW +: DW]), 64'(hand[i]));
                end
            end
        end

        // Abort in cycle 3 of a 7-word copy.
        rom_ofs = 32'h00A0_0000;
        bad1 = 0; bad3 = 0; pre1 = 0; pre3 = 0;
        @(negedge clk);
        src_base = 8'h00; dst_base = 8'h20; word_count = 9'd7; start = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                pre1 += int'(u_dut1.ram_we);
                pre3 += int'(u_dut3.ram_we);
            end else begin
                if ({u_dut1.ram_we, busy1, ready1, done1} != 4'b0 || rd_data1 != '0) bad1++;
                if ({u_dut3.ram_we, busy3, ready3, done3} != 4'b0 || rd_data3 != '0) bad3++;
            end
            start = 1'b0;
            abort = (c == 3);
        end
        abort = 1'b0;
        chk("abort writes up to cycle 3 L1", 64'(pre1), 64'd3);
        chk("abort writes up to cycle 3 L3", 64'(pre3), 64'd1);
        chk("abort quiet cycles L1", 64'(bad1), 64'd0);
        chk("abort quiet cycles L3", 64'(bad3), 64'd0);

        // start together with abort while IDLE must stay IDLE.
        bad1 = 0; bad3 = 0;
        @(negedge clk);
        word_count = 9'd5; start = 1'b1; abort = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if ({u_dut1.ram_we, busy1, ready1, done1} != 4'b0) bad1++;
            if ({u_dut3.ram_we, busy3, ready3, done3} != 4'b0) bad3++;
        end
        chk("start+abort idle L1", 64'(bad1), 64'd0);
        chk("start+abort idle L3", 64'(bad3), 64'd0);

        // Reload after the abort.
        run_xfer('{11, 8'h00, 8'h20, 9'd7, 7, -1});

        // Asynchronous reset in the middle of FILL.
        @(negedge clk);
        src_base = 8'h50; dst_base = 8'h60; word_count = 9'd20; start = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre-reset busy L1", 64'(busy1), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset flags L1", 64'({busy1, ready1, done1}), 64'd0);
        chk("async reset flags L3", 64'({busy3, ready3, done3}), 64'd0);
        chk("async reset rom_addr L1", 64'(rom_addr1), 64'd0);
        chk("async reset rom_addr L3", 64'(rom_addr3), 64'd0);
        chk("async reset rd_data L1", 64'(rd_data1[63:0]), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle after mid reset L1", 64'({busy1, ready1, done1, u_dut1.ram_we}), 64'd0);
        chk("idle after mid reset L3", 64'({busy3, ready3, done3, u_dut3.ram_we}), 64'd0);

        run_xfer('{12, 8'h05, 8'h09, 9'd3, 3, -1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
